// File: rtl/uart_tx_fifo_bridge.sv
// Byte FIFO between the UART receiver and transmitter: buffers received bytes
// and issues them one at a time, waiting for each transmit frame to complete.
module uart_tx_fifo_bridge #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic                  i_rx_done,
  input  logic                  i_tx_done,
  output logic                  o_tx_start,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    BUSY
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_start_q, tx_start_d;
  logic                  overflow_q, overflow_d;
  logic                  full, empty, pop, push;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    tx_data_d  = tx_data_q;
    overflow_d = overflow_q;

    full  = (count_q == FULL_COUNT);
    empty = (count_q == '0);
    pop   = (state_q == IDLE) && !empty;
    // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
    push  = i_rx_done && (!full || pop);

    if (push) begin
      wptr_d = wptr_q + PTR_ONE;
    end
    if (pop) begin
      rptr_d    = rptr_q + PTR_ONE;
      tx_data_d = mem_q[rptr_q];
    end

    case ({push, pop})
      2'b10:   count_d = count_q + COUNT_ONE;
      2'b01:   count_d = count_q - COUNT_ONE;
      default: count_d = count_q;
    endcase

    if (i_rx_done && !push) begin
      overflow_d = 1'b1;
    end

    case (state_q)
      IDLE:    if (pop) state_d = START;
      START:   state_d = BUSY;
      BUSY:    if (i_tx_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    tx_start_d = (state_d == START);
  end

  // NOTE: the storage array is deliberately not reset; a slot is only read after it was written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= i_rx_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_tx_start = tx_start_q;
  assign o_tx_data  = tx_data_q;
  assign o_count    = count_q;
  assign o_full     = (count_q == FULL_COUNT);
  assign o_empty    = (count_q == '0);
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo_bridge.sv
// Bench for uart_tx_fifo_bridge: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations and a randomized soak.
module tb_uart_tx_fifo_bridge;

  logic       clk;
  logic       reset;
  logic [7:0] i_rx_data;
  logic       i_rx_done;
  logic       i_tx_done;
  logic       o_tx_start;
  logic [7:0] o_tx_data;
  logic       o_full;
  logic       o_empty;
  logic [4:0] o_count;
  logic       o_overflow;

  uart_tx_fifo_bridge #(.DEPTH_LOG2(4), .DATA_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_rx_data  (i_rx_data),
    .i_rx_done  (i_rx_done),
    .i_tx_done  (i_tx_done),
    .o_tx_start (o_tx_start),
    .o_tx_data  (o_tx_data),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_count    (o_count),
    .o_overflow (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
  endtask

  // Transmitter stand-in: answers each start with a done pulse after tx_delay edges.
  logic auto_done, manual_done, tx_auto;
  int   tx_delay;
  assign i_tx_done = auto_done | manual_done;

  initial begin
    auto_done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset && o_tx_start && tx_auto) begin
        repeat (tx_delay) @(posedge clk);
        #2 auto_done = 1'b1;
        @(posedge clk);
        #2 auto_done = 1'b0;
      end
    end
  end

  // Reference model: a byte queue plus the transmit phase (0 idle, 1 start, 2 busy).
  logic [7:0] mq[$];
  int         m_phase;
  logic [7:0] m_data;
  logic       m_ovf;
  bit         m_was_full, m_popping;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_phase = 0;
      m_data  = 8'h00;
      m_ovf   = 1'b0;
    end else begin
      m_was_full = (mq.size() == 16);
      m_popping  = (m_phase == 0) && (mq.size() > 0);
      if (m_popping) m_data = mq.pop_front();
      if (i_rx_done) begin
        if (!m_was_full || m_popping) mq.push_back(i_rx_data);
        else m_ovf = 1'b1;
      end
      case (m_phase)
        0:       if (m_popping) m_phase = 1;
        1:       m_phase = 2;
        default: if (i_tx_done) m_phase = 0;
      endcase
    end
  end

  logic [7:0] tx_log[$];
  int         peak;

  always @(negedge clk) begin
    if (reset) begin
      check("tx_start", 32'(o_tx_start), 32'(m_phase == 1));
      check("tx_data",  32'(o_tx_data),  32'(m_data));
      check("count",    32'(o_count),    32'(mq.size()));
      check("full",     32'(o_full),     32'(mq.size() == 16));
      check("empty",    32'(o_empty),    32'(mq.size() == 0));
      check("overflow", 32'(o_overflow), 32'(m_ovf));
      if (o_tx_start) tx_log.push_back(o_tx_data);
      if (int'(o_count) > peak) peak = int'(o_count);
    end
  end

  // Every stimulus step starts and ends 2 time units after a rising edge.
  task automatic push(input logic [7:0] b);
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(posedge clk); #2;
    i_rx_done = 1'b0;
    i_rx_data = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic pulse_done();
    manual_done = 1'b1;
    @(posedge clk); #2;
    manual_done = 1'b0;
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((mq.size() != 0 || m_phase != 0 || auto_done) && n < 3000) begin
      @(posedge clk); #2;
      n++;
    end
    check("drain_in_time", 32'(n < 3000), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_start"}, 32'(o_tx_start), 32'd0);
    check({tag, "_tx_data"},  32'(o_tx_data),  32'd0);
    check({tag, "_count"},    32'(o_count),    32'd0);
    check({tag, "_empty"},    32'(o_empty),    32'd1);
    check({tag, "_full"},     32'(o_full),     32'd0);
    check({tag, "_overflow"}, 32'(o_overflow), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; i_rx_done = 1'b0; i_rx_data = 8'h00;
    manual_done = 1'b0; tx_auto = 1'b0; tx_delay = 1; peak = 0;

    #1 check_reset_outputs("por");
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b1;

    // Single byte: start two edges after the push, count 0 -> 1 -> 0.
    tx_log.delete();
    push(8'h41);
    check("single_count_after_push", 32'(o_count), 32'd1);
    idle(1);
    check("single_start", 32'(o_tx_start), 32'd1);
    check("single_data",  32'(o_tx_data),  32'h41);
    check("single_count_after_pop", 32'(o_count), 32'd0);
    idle(1);
    check("single_start_one_cycle", 32'(o_tx_start), 32'd0);
    idle(10);
    check("single_no_second_start", 32'(tx_log.size()), 32'd1);
    pulse_done();
    idle(10);
    check("single_idle_after_done", 32'(tx_log.size()), 32'd1);

    // Burst ordering with a slow transmitter.
    tx_log.delete(); peak = 0;
    tx_auto = 1'b1; tx_delay = 100;
    for (int i = 1; i <= 5; i++) push(8'(i));
    wait_drain();
    check("burst_len", 32'(tx_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < tx_log.size(); i++)
      check("burst_order", 32'(tx_log[i]), 32'(i + 1));
    check("burst_peak", 32'(peak), 32'd4);

    // Full and overflow with the transmitter stalled.
    tx_log.delete();
    tx_auto = 1'b0;
    for (int i = 0; i < 18; i++) push(8'(8'h10 + i));
    check("ovf_full",  32'(o_full),     32'd1);
    check("ovf_count", 32'(o_count),    32'd16);
    check("ovf_flag",  32'(o_overflow), 32'd1);
    check("ovf_first_start", 32'(tx_log.size()), 32'd1);
    if (tx_log.size() > 0) check("ovf_first_data", 32'(tx_log[0]), 32'h10);
    tx_auto = 1'b1; tx_delay = 3;
    pulse_done();
    wait_drain();
    check("ovf_drain_len", 32'(tx_log.size()), 32'd17);
    for (int i = 0; i < 17 && i < tx_log.size(); i++)
      check("ovf_drain_order", 32'(tx_log[i]), 32'(8'h10 + i));
    check("ovf_sticky", 32'(o_overflow), 32'd1);

    // Wrap-around: 40 bytes in bursts of 7.
    do_reset();
    tx_log.delete();
    tx_auto = 1'b1; tx_delay = 5;
    for (int i = 0; i < 40; i++) begin
      push(8'(i));
      if (i % 7 == 6) idle(40);
    end
    wait_drain();
    check("wrap_len", 32'(tx_log.size()), 32'd40);
    for (int i = 0; i < 40 && i < tx_log.size(); i++)
      check("wrap_order", 32'(tx_log[i]), 32'(i));
    check("wrap_no_overflow", 32'(o_overflow), 32'd0);
    check("wrap_empty", 32'(o_empty), 32'd1);

    // Push on the pop edge while full.
    tx_log.delete();
    tx_auto = 1'b0;
    push(8'h50);
    idle(2);
    for (int i = 0; i < 16; i++) push(8'(8'h60 + i));
    check("edge_full", 32'(o_full), 32'd1);
    pulse_done();
    tx_auto = 1'b1; tx_delay = 2;
    push(8'hAA);
    check("edge_count", 32'(o_count), 32'd16);
    check("edge_no_overflow", 32'(o_overflow), 32'd0);
    check("edge_start", 32'(o_tx_start), 32'd1);
    check("edge_data", 32'(o_tx_data), 32'h60);
    wait_drain();
    check("edge_len", 32'(tx_log.size()), 32'd18);
    if (tx_log.size() > 0) check("edge_last", 32'(tx_log[tx_log.size() - 1]), 32'hAA);

    // Mid-transmission asynchronous reset.
    tx_log.delete();
    tx_auto = 1'b0;
    push(8'h70);
    idle(2);
    for (int i = 1; i <= 3; i++) push(8'(8'h70 + i));
    check("mid_queued", 32'(o_count), 32'd3);
    #2 reset = 1'b0;
    #1 check_reset_outputs("mid");
    @(posedge clk); #2;
    reset = 1'b1;
    idle(10);
    pulse_done();
    idle(10);
    check("mid_no_start", 32'(tx_log.size()), 32'd1);
    push(8'h99);
    idle(3);
    check("mid_new_start", 32'(tx_log.size()), 32'd2);
    if (tx_log.size() > 1) check("mid_new_data", 32'(tx_log[1]), 32'h99);
    pulse_done();
    idle(3);

    // Randomized soak; the per-cycle compare does the checking.
    tx_auto = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      tx_delay  = int'($urandom_range(1, 30));
      i_rx_data = 8'($urandom);
      i_rx_done = ($urandom_range(0, 3) == 0);
      @(posedge clk); #2;
    end
    i_rx_done = 1'b0;
    wait_drain();
    check("soak_empty", 32'(o_empty), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_bridge.md
# uart_tx_fifo_bridge

Byte buffer and transmit sequencer between the UART receiver and the UART transmitter in the loopback path. Accepts each received byte on the receiver's one-cycle done pulse, stores it in a circular FIFO, and hands bytes to the transmitter one at a time with a one-cycle start pulse. It waits for the transmitter's done pulse before issuing the next byte. Its purpose is to prevent back-to-back received bytes from being lost while the transmitter is busy.

## Interface
- DEPTH_LOG2, 4: FIFO depth is 2^DEPTH_LOG2 entries (16).
- DATA_WIDTH, 8: byte width.
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- i_rx_data  input  DATA_WIDTH  received byte; valid only while i_rx_done = 1.
- i_rx_done  input  1  one-cycle pulse from the receiver: push i_rx_data.
- i_tx_done  input  1  one-cycle pulse from the transmitter: the current byte has finished.
- o_tx_start  output  1  one-cycle pulse to the transmitter: begin sending o_tx_data.
- o_tx_data  output  DATA_WIDTH  byte to transmit; held stable from the start pulse until the next start pulse.
- o_full  output  1  count == 2^DEPTH_LOG2.
- o_empty  output  1  count == 0.
- o_count  output  DEPTH_LOG2+1  number of stored bytes.
- o_overflow  output  1  sticky flag; set when a byte is dropped, cleared only by reset.

## Operation
**Storage**
- Memory is 2^DEPTH_LOG2 × DATA_WIDTH.
- Write pointer and read pointer are each DEPTH_LOG2 bits and wrap modulo depth.
- Count is tracked separately, which gives unambiguous full/empty.

**Push**
- A push occurs when i_rx_done = 1 and (not full, or a pop occurs in the same cycle).
- On a push, write mem[wptr] and increment wptr.

**Pop**
- Performed only by the FSM in IDLE when count > 0.
- On a pop, o_tx_data <= mem[rptr] and rptr is incremented.

**Count update**
- Push without pop: +1.
- Pop without push: −1.
- Both or neither: unchanged.

**Overflow**
- Condition: i_rx_done = 1, full, and no pop in the same cycle.
- Result: the byte is dropped, pointers and count are unchanged, and o_overflow <= 1.

**FSM states:** IDLE, START, BUSY.
- IDLE: if count > 0, pop and go to START. Otherwise stay in IDLE.
- START: o_tx_start = 1 for exactly this cycle; go to BUSY unconditionally.
- BUSY: wait. On i_tx_done = 1, go to IDLE.
- i_tx_done received in IDLE or START is ignored.
- o_tx_start is decoded from state == START; it is registered-state driven and glitch-free.

**Reset** (asynchronous, reset = 0)
- FSM goes to IDLE.
- wptr, rptr and count go to 0.
- o_tx_data = 0, o_tx_start = 0, o_overflow = 0.
- o_empty = 1, o_full = 0, o_count = 0.
- Memory contents are don't-care.
- If reset is asserted mid-transmission, the in-flight byte and all buffered bytes are discarded.
- After reset is released, the block behaves as freshly reset.

## Timing
- **Push:** an edge E sampling i_rx_done = 1 updates mem and count at E. o_count and o_empty reflect the new count after E.
- **Latency from an empty FIFO in IDLE:**
  - i_rx_done sampled at edge E.
  - Pop at E+1, with o_tx_data valid after E+1.
  - o_tx_start high during the cycle between E+1 and E+2.
  - FSM is in BUSY after E+2.
- **Turnaround:** i_tx_done sampled at edge T gives IDLE after T. With data pending, o_tx_start is next high in the cycle after T+1, giving a minimum gap of 2 cycles between done and the next start.
- **Push and pop in the same edge:**
  - Both take effect and count is unchanged.
  - If full, the push is accepted because of the simultaneous pop.
  - If the FIFO is empty, the pop does not happen (FSM requires count > 0), so this case reduces to push only.
- **Throughput:** at most one byte per transmitter frame. The FIFO absorbs bursts of up to 2^DEPTH_LOG2 bytes.
- o_tx_data changes only on the pop edge (IDLE→START).

## Test plan
- **Single byte:** reset, then i_rx_done pulse with i_rx_data = 0x41.
  - o_tx_start pulses once, 2 cycles later, with o_tx_data = 0x41.
  - o_count goes 0→1→0.
  - No second start until i_tx_done is pulsed.
- **Burst ordering:** push 0x01..0x05 on consecutive cycles while the transmitter model delays i_tx_done by 100 cycles each.
  - Start pulses carry 0x01..0x05 in order, exactly one per i_tx_done.
  - o_count peaks at 4.
- **Full/overflow:** hold i_tx_done low, push 18 bytes 0x10..0x21.
  - The first start carries 0x10 (popped).
  - o_full = 1 at count 16.
  - The 18th byte (0x21) is dropped and o_overflow = 1.
  - Draining yields 0x11..0x20.
  - o_overflow stays 1 until reset.
- **Wrap-around:** push/drain 40 bytes 0x00..0x27 in bursts of 7.
  - The transmitted sequence equals the input.
  - No overflow occurs.
  - o_empty = 1 at the end.
- **Push on pop edge when full:**
  - Setup: fill to 16 while in BUSY, then pulse i_tx_done.
  - Stimulus: push 0xAA on the exact pop edge.
  - Count stays 16, o_overflow = 0, and 0xAA is transmitted last.
- **Mid-operation reset:** in BUSY with 3 bytes queued, assert reset low for 1 cycle asynchronously.
  - All outputs are at reset values immediately.
  - No start pulse occurs after release until a new i_rx_done.
  - A stray i_tx_done after release is ignored.
